stream_encoder: RTL

STREAM_ENCODER -- requirements
Module: stream_encoder

---
 rtl/stream_encoder_pkg.sv | 35 +++
 rtl/validity_mask_applier.sv | 19 +
 rtl/stream_encoder.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/stream_encoder_pkg.sv
// Shared definitions for the stream encoder: command opcodes, status nibbles,
// FSM state encoding and the header/status word formers.
package stream_encoder_pkg;

    localparam logic [1:0] OP_DATA   = 2'd0;
    localparam logic [1:0] OP_TAG    = 2'd1;
    localparam logic [1:0] OP_STATUS = 2'd2;
    localparam logic [1:0] OP_RSVD   = 2'd3;

    localparam logic [3:0] STATUS_OK   = 4'hE;
    localparam logic [3:0] STATUS_FAIL = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        BODY = 2'd2,
        STAT = 2'd3
    } state_e;

    // Header layout: dtype | 0 | eoi | eot | last | 8'h00 | length
    function automatic logic [31:0] header_encoder(
        input logic [3:0]  dtype,
        input logic        eoi,
        input logic        eot,
        input logic        last,
        input logic [15:0] length
    );
        return {dtype, 1'b0, eoi, eot, last, 8'h00, length};
    endfunction

    function automatic logic [31:0] status_encoder(input logic success);
        return {(success ? STATUS_OK : STATUS_FAIL), 28'h0};
    endfunction

endpackage

// File: rtl/validity_mask_applier.sv
// Zeroes every byte of a bus word whose validity bit is clear.
module validity_mask_applier #(
    parameter int BUS_SIZE = 32
) (
    input  logic [BUS_SIZE-1:0]   word_i,
    input  logic [BUS_SIZE/8-1:0] valid_i,
    output logic [BUS_SIZE-1:0]   word_o
);

    always_comb begin
        word_o = '0;
        for (int j = 0; j < BUS_SIZE / 8; j++) begin
            if (valid_i[j]) begin
                word_o[8*j +: 8] = word_i[8*j +: 8];
            end
        end
    end

endmodule

// File: rtl/stream_encoder.sv
// Serialises header, status, tag and masked data-block commands into a
// valid/ready word stream of BUS_SIZE bits, one word per accepted beat.
module stream_encoder
    import stream_encoder_pkg::*;
#(
    parameter int BUS_SIZE  = 32,
    parameter int BLCK_SIZE = 256,
    parameter int n         = 128
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic                   cmd_hdr,
    input  logic [3:0]             head_dtype,
    input  logic                   head_eot,
    input  logic                   head_eoi,
    input  logic                   head_last,
    input  logic [15:0]            head_length,
    input  logic                   status_sel,
    input  logic [BLCK_SIZE-1:0]   blk_data,
    input  logic [BLCK_SIZE/8-1:0] blk_validity,
    input  logic [n-1:0]           tag,
    output logic [BUS_SIZE-1:0]    data_out,
    output logic                   data_out_valid,
    input  logic                   data_out_ready,
    output logic                   busy
);

    localparam int BYTES      = BUS_SIZE / 8;
    localparam int DATA_WORDS = BLCK_SIZE / BUS_SIZE;
    localparam int TAG_WORDS  = n / BUS_SIZE;
    localparam int MAX_WORDS  = (DATA_WORDS > TAG_WORDS) ? DATA_WORDS : TAG_WORDS;
    localparam int IDX_W      = $clog2(MAX_WORDS) + 1;

    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_WORDS - 1);
    localparam logic [IDX_W-1:0] LAST_TAG  = IDX_W'(TAG_WORDS - 1);

    state_e                 state_q;
    logic [IDX_W-1:0]       idx_q;
    logic [BUS_SIZE-1:0]    dataOut_q;
    logic                   dataOutValid_q;

    logic                   isTag_q;
    logic [BLCK_SIZE-1:0]   blkData_q;
    logic [BLCK_SIZE/8-1:0] validity_q;
    logic [n-1:0]           tag_q;

    logic                   accept;
    logic [BLCK_SIZE-1:0]   srcData;
    logic [BLCK_SIZE/8-1:0] srcValid;
    logic [n-1:0]           srcTag;
    logic [IDX_W-1:0]       wordIdx_d;
    logic [IDX_W-1:0]       dataSel;
    logic [IDX_W-1:0]       tagSel;
    logic [BUS_SIZE-1:0]    rawWord;
    logic [BYTES-1:0]       wordValid;
    logic [BUS_SIZE-1:0]    maskedWord;
    logic                   wordPresent;
    logic [BUS_SIZE-1:0]    tagWord;
    logic [BUS_SIZE-1:0]    hdrWord;
    logic [BUS_SIZE-1:0]    statWord;
    logic                   lastWord;

    function automatic logic [BUS_SIZE-1:0] placeTop(input logic [31:0] w);
        logic [BUS_SIZE-1:0] r;
        r = '0;
        r[BUS_SIZE-1 -: 32] = w;
        return r;
    endfunction

    assign accept    = cmd_valid && (state_q == IDLE);
    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);

    assign data_out       = dataOut_q;
    assign data_out_valid = dataOutValid_q;

    // The first body word is formed straight from the inputs on the accept
    // edge; every later word comes from the captured copies.
    assign srcData  = accept ? blk_data     : blkData_q;
    assign srcValid = accept ? blk_validity : validity_q;
    assign srcTag   = accept ? tag          : tag_q;

    assign wordIdx_d = (state_q == BODY) ? idx_q + IDX_W'(1) : '0;
    assign dataSel   = (wordIdx_d > LAST_DATA) ? '0 : wordIdx_d;
    assign tagSel    = (wordIdx_d > LAST_TAG)  ? '0 : wordIdx_d;

    assign rawWord     = srcData[dataSel*BUS_SIZE +: BUS_SIZE];
    assign wordValid   = srcValid[dataSel*BYTES +: BYTES];
    assign wordPresent = |wordValid;
    assign tagWord     = srcTag[tagSel*BUS_SIZE +: BUS_SIZE];

    validity_mask_applier #(
        .BUS_SIZE(BUS_SIZE)
    ) u_mask (
        .word_i (rawWord),
        .valid_i(wordValid),
        .word_o (maskedWord)
    );

    assign hdrWord  = placeTop(header_encoder(head_dtype, head_eoi, head_eot,
                                              head_last, head_length));
    assign statWord = placeTop(status_encoder(status_sel));
    assign lastWord = isTag_q ? (idx_q == LAST_TAG) : (idx_q == LAST_DATA);

    always_ff @(posedge clk) begin
        if (accept) begin
            isTag_q    <= (cmd_op == OP_TAG);
            blkData_q  <= blk_data;
            validity_q <= blk_validity;
            tag_q      <= tag;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            dataOut_q      <= '0;
            dataOutValid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        idx_q <= '0;
                        if (cmd_op == OP_DATA || cmd_op == OP_TAG) begin
                            if (cmd_hdr) begin
                                state_q        <= HDR;
                                dataOut_q      <= hdrWord;
                                dataOutValid_q <= 1'b1;
                            end else begin
                                // An empty DATA block parks one cycle in BODY
                                // with valid low, then returns to IDLE.
                                state_q        <= BODY;
                                dataOut_q      <= (cmd_op == OP_TAG) ? tagWord : maskedWord;
                                dataOutValid_q <= (cmd_op == OP_TAG) || wordPresent;
                            end
                        end else begin
                            state_q        <= STAT;
                            dataOut_q      <= statWord;
                            dataOutValid_q <= 1'b1;
                        end
                    end
                end
                HDR: begin
                    if (data_out_ready) begin
                        idx_q <= '0;
                        if (isTag_q || wordPresent) begin
                            state_q        <= BODY;
                            dataOut_q      <= isTag_q ? tagWord : maskedWord;
                            dataOutValid_q <= 1'b1;
                        end else begin
                            state_q        <= IDLE;
                            dataOut_q      <= '0;
                            dataOutValid_q <= 1'b0;
                        end
                    end
                end
                BODY: begin
                    if (!dataOutValid_q) begin
                        state_q <= IDLE;
                        idx_q   <= '0;
                    end else if (data_out_ready) begin
                        if (lastWord || (!isTag_q && !wordPresent)) begin
                            state_q        <= IDLE;
                            idx_q          <= '0;
                            dataOut_q      <= '0;
                            dataOutValid_q <= 1'b0;
                        end else begin
                            idx_q          <= wordIdx_d;
                            dataOut_q      <= isTag_q ? tagWord : maskedWord;
                            dataOutValid_q <= 1'b1;
                        end
                    end
                end
                STAT: begin
                    if (data_out_ready) begin
                        state_q        <= IDLE;
                        dataOut_q      <= '0;
                        dataOutValid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q        <= IDLE;
                    idx_q          <= '0;
                    dataOut_q      <= '0;
                    dataOutValid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
